// File: rtl/lfsr_decrypt_engine.sv
// lfsr_decrypt_engine
// Memory-mastering decryptor for parity-tagged 7-bit LFSR ciphertext.
// It reads the known space preamble, finds which of nine candidate taps
// reproduces the key stream, and then writes the decrypted message back.
// Optional build macro: PARITY_MARK_EN. When it is defined, a byte whose
// parity bit is wrong is written as 8'h80 instead of its decrypted value.
module lfsr_decrypt_engine #(
  parameter int CT_BASE = 64,
  parameter int PT_BASE = 0,
  parameter int MSG_LEN = 64,
  parameter int PRE_MIN = 10,
  parameter int AW      = 8
) (
  input  logic          clk,
  input  logic          init,
  input  logic          req,
  output logic          ack,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data,
  output logic          found,
  output logic [3:0]    ptrn_idx,
  output logic [6:0]    par_err_cnt
);

  localparam int KIW = (PRE_MIN > 2) ? $clog2(PRE_MIN) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_MATCH,
    S_DEC,
    S_DONE
  } state_t;

  state_t          state_q;
  logic            armed_q;
  logic            ack_q;
  logic [AW-1:0]   addr_q;
  logic            wr_en_q;
  logic [7:0]      wr_last_q;
  logic            found_q;
  logic [3:0]      idx_q;
  logic [6:0]      par_q;
  logic [6:0]      cnt_q;
  logic [3:0]      cand_q;
  logic [KIW-1:0]  j_q;
  logic [6:0]      s_q;
  logic [6:0]      kbuf_q [PRE_MIN];

  logic [6:0]      s_step;
  logic            ct_bad;
  logic [7:0]      wr_byte;

  function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] tap);
    return {s[5:0], ^(s & tap)};
  endfunction

  function automatic logic [6:0] tap_rom(input logic [3:0] i);
    case (i)
      4'd0:    return 7'h60;
      4'd1:    return 7'h48;
      4'd2:    return 7'h78;
      4'd3:    return 7'h72;
      4'd4:    return 7'h6A;
      4'd5:    return 7'h69;
      4'd6:    return 7'h5C;
      4'd7:    return 7'h7E;
      4'd8:    return 7'h7B;
      default: return 7'h60;
    endcase
  endfunction

  function automatic logic [AW-1:0] ct_addr(input logic [6:0] i);
    return AW'(CT_BASE) + AW'(i);
  endfunction

  function automatic logic [AW-1:0] pt_addr(input logic [6:0] i);
    return AW'(PT_BASE) + AW'(i);
  endfunction

  // Next LFSR state for the candidate under test (or the matched tap in DEC),
  // parity check of the byte on the read bus, and the byte to be written.
  always_comb begin
    s_step = lfsr_step(s_q, tap_rom(cand_q));
    ct_bad = mem_rd_data[7] ^ (^mem_rd_data[6:0]);
`ifdef PARITY_MARK_EN
    wr_byte = ct_bad ? 8'h80 : {1'b0, mem_rd_data[6:0] ^ s_q};
`else
    wr_byte = {1'b0, mem_rd_data[6:0] ^ s_q};
`endif
  end

  // Read data only arrives during the write cycle, so the write bus is fed
  // straight from it then and otherwise shows the last byte written.
  assign mem_wr_data = wr_en_q ? wr_byte : wr_last_q;
  assign ack         = ack_q;
  assign mem_addr    = addr_q;
  assign mem_wr_en   = wr_en_q;
  assign found       = found_q;
  assign ptrn_idx    = idx_q;
  assign par_err_cnt = par_q;

  // Preamble key capture: k[c-1] arrives one cycle after address CT_BASE+c-1.
  always_ff @(posedge clk) begin
    if (state_q == S_FETCH && cnt_q != 7'd0)
      kbuf_q[KIW'(cnt_q - 7'd1)] <= mem_rd_data[6:0] ^ 7'h20;
  end

  // Control FSM: arm/start handshake, preamble fetch, tap search, decrypt loop.
  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      state_q   <= S_IDLE;
      armed_q   <= 1'b0;
      ack_q     <= 1'b0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_last_q <= 8'h00;
      found_q   <= 1'b0;
      idx_q     <= 4'd0;
      par_q     <= 7'd0;
      cnt_q     <= 7'd0;
      cand_q    <= 4'd0;
      j_q       <= '0;
      s_q       <= 7'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            armed_q <= 1'b0;
            found_q <= 1'b0;
            idx_q   <= 4'd0;
            par_q   <= 7'd0;
            cnt_q   <= 7'd0;
            addr_q  <= ct_addr(7'd0);
            state_q <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (cnt_q == 7'(PRE_MIN)) begin
            cand_q  <= 4'd0;
            j_q     <= KIW'(1);
            s_q     <= kbuf_q[0];
            state_q <= S_MATCH;
          end else begin
            cnt_q <= cnt_q + 7'd1;
            if (cnt_q < 7'(PRE_MIN - 1))
              addr_q <= ct_addr(cnt_q + 7'd1);
          end
        end

        S_MATCH: begin
          if (s_step == kbuf_q[j_q]) begin
            if (j_q == KIW'(PRE_MIN - 1)) begin
              found_q <= 1'b1;
              idx_q   <= cand_q;
              s_q     <= kbuf_q[0];
              cnt_q   <= 7'd0;
              addr_q  <= ct_addr(7'd0);
              state_q <= S_DEC;
            end else begin
              j_q <= j_q + KIW'(1);
              s_q <= s_step;
            end
          end else if (cand_q == 4'd8) begin
            found_q <= 1'b0;
            ack_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cand_q <= cand_q + 4'd1;
            j_q    <= KIW'(1);
            s_q    <= kbuf_q[0];
          end
        end

        S_DEC: begin
          if (!wr_en_q) begin
            wr_en_q <= 1'b1;
            addr_q  <= pt_addr(cnt_q);
          end else begin
            wr_en_q   <= 1'b0;
            wr_last_q <= wr_byte;
            s_q       <= s_step;
            if (ct_bad && par_q != 7'h7F)
              par_q <= par_q + 7'd1;
            if (cnt_q == 7'(MSG_LEN - 1)) begin
              ack_q   <= 1'b1;
              state_q <= S_DONE;
            end else begin
              cnt_q  <= cnt_q + 7'd1;
              addr_q <= ct_addr(cnt_q + 7'd1);
            end
          end
        end

        S_DONE: begin
          if (req) begin
            ack_q   <= 1'b0;
            armed_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_decrypt_engine.sv
// Bench for lfsr_decrypt_engine: synchronous memory model, ciphertext
// generator, and a behavioural decrypt/search model checked against the DUT.
module tb_lfsr_decrypt_engine;
  localparam int CT_BASE = 64;
  localparam int PT_BASE = 0;
  localparam int MSG_LEN = 64;
  localparam int PRE_MIN = 10;
  localparam int AW      = 8;
  localparam int LAT_MAX = (PRE_MIN + 1) + 8 * (PRE_MIN - 1) + (PRE_MIN - 1) + 2 * MSG_LEN;
  localparam bit [6:0] TAPS [0:8] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};

  logic          clk = 1'b0;
  logic          init;
  logic          req;
  logic          ack;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rd_data;
  logic          mem_wr_en;
  logic [7:0]    mem_wr_data;
  logic          found;
  logic [3:0]    ptrn_idx;
  logic [6:0]    par_err_cnt;

  always #5 clk = ~clk;

  lfsr_decrypt_engine #(
    .CT_BASE(CT_BASE), .PT_BASE(PT_BASE), .MSG_LEN(MSG_LEN), .PRE_MIN(PRE_MIN), .AW(AW)
  ) dut (
    .clk(clk), .init(init), .req(req), .ack(ack),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .found(found), .ptrn_idx(ptrn_idx), .par_err_cnt(par_err_cnt)
  );

  logic [7:0] mem [256];
  logic [7:0] img [256];
  logic       ld;

  always @(posedge clk) begin
    mem_rd_data <= mem[mem_addr];
    if (ld) begin
      for (int a = 0; a < 256; a++) mem[a] <= img[a];
    end else if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  logic [7:0] pt [64];
  logic [7:0] exp_wr [64];
  int         n_exp;
  bit         exp_found;
  int         exp_idx;
  int         exp_par;
  time        t_start;

  function automatic logic [6:0] nxt(input logic [6:0] s, input logic [6:0] t);
    return {s[5:0], 1'($countones(s & t) % 2)};
  endfunction

  // Write monitor: every write must be the next expected plaintext byte.
  bit  clr_tog = 1'b0;
  bit  clr_seen = 1'b0;
  int  wr_seen = 0;
  time first_wr_t = 0;
  always @(negedge clk) begin
    if (clr_tog != clr_seen) begin
      clr_seen = clr_tog;
      wr_seen = 0;
      first_wr_t = 0;
    end
    if (init === 1'b1 && mem_wr_en === 1'b1) begin
      if (wr_seen == 0) first_wr_t = $time;
      if (wr_seen >= n_exp) begin
        chk("write_allowed", 32'(wr_seen < n_exp), 32'd1);
      end else begin
        chk("wr_addr", 32'(mem_addr), 32'((PT_BASE + wr_seen) % 256));
        chk("wr_data", 32'(mem_wr_data), 32'(exp_wr[wr_seen]));
      end
      wr_seen++;
    end
  end

  task automatic build_msg(input string m);
    for (int i = 0; i < 64; i++)
      pt[i] = (i >= 10 && (i - 10) < m.len()) ? 8'(m[i - 10]) : 8'h20;
  endtask

  task automatic prefill();
    for (int i = 0; i < MSG_LEN; i++) img[PT_BASE + i] = 8'hA5 ^ 8'(i * 7);
  endtask

  task automatic encrypt(input int tapi, input logic [6:0] k0);
    logic [6:0] key;
    logic [6:0] c;
    key = k0;
    for (int i = 0; i < MSG_LEN; i++) begin
      c = pt[i][6:0] ^ key;
      img[CT_BASE + i] = {1'($countones(c) % 2), c};
      key = nxt(key, TAPS[tapi]);
    end
  endtask

  // Reference: search taps in ROM order over the preamble, then decrypt.
  task automatic model();
    logic [6:0] k [64];
    logic [6:0] s;
    logic [7:0] c;
    bit ok;
    bit bad;
    for (int i = 0; i < MSG_LEN; i++) k[i] = img[CT_BASE + i][6:0] ^ 7'h20;
    exp_found = 0; exp_idx = 0; n_exp = 0; exp_par = 0;
    for (int p = 0; p < 9 && !exp_found; p++) begin
      s = k[0];
      ok = 1;
      for (int j = 1; j < PRE_MIN; j++) begin
        s = nxt(s, TAPS[p]);
        if (s != k[j]) ok = 0;
      end
      if (ok) begin exp_found = 1; exp_idx = p; end
    end
    if (exp_found) begin
      s = k[0] ^ 7'h20 ^ 7'h20;
      s = img[CT_BASE][6:0] ^ 7'h20;
      n_exp = MSG_LEN;
      for (int i = 0; i < MSG_LEN; i++) begin
        c = img[CT_BASE + i];
        bad = (c[7] != 1'($countones(c[6:0]) % 2));
        if (bad && exp_par < 127) exp_par++;
`ifdef PARITY_MARK_EN
        exp_wr[i] = bad ? 8'h80 : {1'b0, c[6:0] ^ s};
`else
        exp_wr[i] = {1'b0, c[6:0] ^ s};
`endif
        s = nxt(s, TAPS[exp_idx]);
      end
    end
  endtask

  task automatic load_mem();
    @(negedge clk) ld = 1'b1;
    @(negedge clk) ld = 1'b0;
  endtask

  task automatic start_run();
    @(negedge clk) req = 1'b1;
    clr_tog = ~clr_tog;
    @(negedge clk);
    req = 1'b0;
    t_start = $time;
  endtask

  task automatic wait_ack(output int cyc);
    cyc = 0;
    while (ack !== 1'b1 && cyc < LAT_MAX + 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("ack_rise", 32'(ack), 32'd1);
  endtask

  task automatic check_end(input string tag);
    int bad;
    logic [7:0] e;
    chk({tag, "_found"}, 32'(found), 32'(exp_found));
    chk({tag, "_idx"}, 32'(ptrn_idx), 32'(exp_idx));
    chk({tag, "_par"}, 32'(par_err_cnt), 32'(exp_par));
    chk({tag, "_nwrites"}, 32'(wr_seen), 32'(n_exp));
    bad = 0;
    for (int i = 0; i < MSG_LEN; i++) begin
      e = (i < n_exp) ? exp_wr[i] : img[PT_BASE + i];
      if (mem[PT_BASE + i] !== e) bad++;
    end
    chk({tag, "_mem_bad_bytes"}, 32'(bad), 32'd0);
  endtask

  task automatic check_text(input string tag, input int skip);
    int bad;
    bad = 0;
    for (int i = 0; i < MSG_LEN; i++)
      if (i != skip && mem[PT_BASE + i] !== pt[i]) bad++;
    chk({tag, "_text_bad_bytes"}, 32'(bad), 32'd0);
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_ack"}, 32'(ack), 32'd0);
    chk({tag, "_wr_en"}, 32'(mem_wr_en), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(mem_wr_data), 32'd0);
    chk({tag, "_found"}, 32'(found), 32'd0);
    chk({tag, "_idx"}, 32'(ptrn_idx), 32'd0);
    chk({tag, "_par"}, 32'(par_err_cnt), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int w;
    int bad;
    int tapi;
    logic [6:0] k0;
    logic [7:0] exp30;
    string msg;

    msg = "Knowledge comes, but wisdom lingers";
    init = 1'b0; req = 1'b0; ld = 1'b0;
    for (int a = 0; a < 256; a++) img[a] = 8'h00;
    #12;
    check_reset_outs("por");
    @(negedge clk) init = 1'b1;

    // Case 1: tap 0x60, init 0x01
    build_msg(msg);
    prefill();
    encrypt(0, 7'h01);
    chk("pin_ct0", 32'(img[CT_BASE]), 32'h21);
    chk("pin_ct1", 32'(img[CT_BASE + 1]), 32'h22);
    chk("pin_pt10", 32'(pt[10]), 32'h4B);
    model();
    chk("pin_model_idx0", 32'(exp_idx), 32'd0);
    load_mem();
    start_run();
    wait_ack(cyc);
    chk("latency_within_bound", 32'(cyc <= LAT_MAX + 1), 32'd1);
    check_end("c1");
    chk("c1_found_lit", 32'(found), 32'd1);
    chk("c1_idx_lit", 32'(ptrn_idx), 32'd0);
    check_text("c1", -1);

    // Hold req low in DONE: no restart, ack held
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("ack_hold", 32'(ack), 32'd1);
    end
    chk("no_restart_writes", 32'(wr_seen), 32'(MSG_LEN));
    @(negedge clk) req = 1'b1;
    @(negedge clk);
    chk("ack_drop", 32'(ack), 32'd0);
    prefill();
    load_mem();
    start_run();
    wait_ack(cyc);
    check_end("c1_again");
    check_text("c1_again", -1);

    // Case 2: tap 0x7B (index 8), init 0x5A
    prefill();
    encrypt(8, 7'h5A);
    chk("pin_ct0_b", 32'(img[CT_BASE]), 32'hFA);
    model();
    chk("pin_model_idx8", 32'(exp_idx), 32'd8);
    load_mem();
    start_run();
    wait_ack(cyc);
    check_end("c2");
    chk("c2_idx_lit", 32'(ptrn_idx), 32'd8);
    chk("c2_no_early_write", 32'(((first_wr_t - t_start) / 10) >= 29), 32'd1);
    check_text("c2", -1);

    // Case 3: all-zero ciphertext, no tap can match
    prefill();
    for (int i = 0; i < MSG_LEN; i++) img[CT_BASE + i] = 8'h00;
    model();
    chk("pin_model_nofind", 32'(exp_found), 32'd0);
    load_mem();
    start_run();
    wait_ack(cyc);
    check_end("c3");
    chk("c3_found_lit", 32'(found), 32'd0);

    // Case 4: parity bit of byte 30 flipped
    prefill();
    encrypt(0, 7'h01);
    img[CT_BASE + 30] = img[CT_BASE + 30] ^ 8'h80;
    model();
    load_mem();
    start_run();
    wait_ack(cyc);
    check_end("c4");
    chk("c4_par_lit", 32'(par_err_cnt), 32'd1);
`ifdef PARITY_MARK_EN
    exp30 = 8'h80;
`else
    exp30 = pt[30];
`endif
    chk("c4_byte30", 32'(mem[PT_BASE + 30]), 32'(exp30));
    check_text("c4", 30);

    // Case 5: reset during DEC after 20 writes, then a full re-run
    prefill();
    encrypt(0, 7'h01);
    model();
    load_mem();
    start_run();
    w = 0;
    while (wr_seen < 20 && w < LAT_MAX + 50) begin
      @(negedge clk);
      w++;
    end
    chk("c5_reach20", 32'(wr_seen), 32'd20);
    @(posedge clk);
    #2 init = 1'b0;
    n_exp = 20;
    #1;
    check_reset_outs("midrun_rst");
    repeat (3) @(negedge clk);
    init = 1'b1;
    repeat (6) @(negedge clk);
    chk("c5_no_restart", 32'(ack), 32'd0);
    chk("c5_writes_stopped", 32'(wr_seen), 32'd20);
    bad = 0;
    for (int i = 0; i < MSG_LEN; i++)
      if (mem[PT_BASE + i] !== ((i < 20) ? pt[i] : img[PT_BASE + i])) bad++;
    chk("c5_partial_mem", 32'(bad), 32'd0);
    model();
    load_mem();
    start_run();
    wait_ack(cyc);
    check_end("c5_rerun");
    check_text("c5_rerun", -1);

    // Randomized runs: random tap, init, text and parity flips
    for (int r = 0; r < 6; r++) begin
      tapi = $urandom_range(0, 8);
      k0 = 7'($urandom_range(1, 127));
      for (int i = 0; i < 64; i++)
        pt[i] = (i < 10) ? 8'h20 : 8'($urandom_range(32, 126));
      prefill();
      encrypt(tapi, k0);
      for (int i = 0; i < MSG_LEN; i++)
        if ($urandom_range(0, 7) == 0) img[CT_BASE + i] = img[CT_BASE + i] ^ 8'h80;
      model();
      load_mem();
      start_run();
      wait_ack(cyc);
      chk("rnd_latency_within_bound", 32'(cyc <= LAT_MAX + 1), 32'd1);
      check_end("rnd");
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lfsr_decrypt_engine.md
Name: lfsr_decrypt_engine

Overview:
Hardware decryption engine for the Program #2 flow. It consumes the 64-byte parity-tagged LFSR ciphertext that the encryption stage leaves in data memory at 64..127. It recovers the tap pattern and starting state from the known space-character preamble, then writes the 64 decrypted bytes to data memory 0..63. It sits beside top_level's core as a memory master and uses the same req/ack start/done protocol.

Parameters:
CT_BASE, 64, data-memory address of ciphertext byte 0
PT_BASE, 0, data-memory address of plaintext byte 0
MSG_LEN, 64, bytes processed per run (2..64)
PRE_MIN, 10, guaranteed preamble spaces used for pattern search (2..MSG_LEN)
AW, 8, data-memory address width

Ports:
clk  in  1  rising-edge clock
init  in  1  asynchronous active-low reset
req  in  1  1 = hold/arm; first cycle low after armed starts a run
ack  out  1  run complete; held until req returns high
mem_addr  out  AW  data-memory address
mem_rd_data  in  8  read data; synchronous memory, valid 1 cycle after mem_addr
mem_wr_en  out  1  write strobe for mem_addr/mem_wr_data
mem_wr_data  out  8  plaintext byte
found  out  1  a tap pattern matched the preamble
ptrn_idx  out  4  index 0..8 of the matched pattern
par_err_cnt  out  7  ciphertext bytes with bad parity (saturates at 127)

Behaviour:
- Reset (init=0, async): state IDLE; armed=0; ack=0; mem_wr_en=0; mem_addr=0; mem_wr_data=0; found=0; ptrn_idx=0; par_err_cnt=0.
- Reset mid-run aborts immediately. No further writes occur. Bytes already written stay in memory.
- Candidate taps, fixed ROM in index order: 0x60, 0x48, 0x78, 0x72, 0x6A, 0x69, 0x5C, 0x7E, 0x7B.
- LFSR step: next = {s[5:0], ^(s & tap)}.
- Key stream: k[i] = ct[i][6:0] ^ 7'h20 for i < PRE_MIN.
- IDLE:
  - req=1 sets armed.
  - If armed and req=0: clear found, ptrn_idx and par_err_cnt, then go to FETCH.
- FETCH:
  - Issues reads CT_BASE+0..PRE_MIN-1 on consecutive cycles.
  - Captures k[0..PRE_MIN-1] into a PRE_MIN x 7 buffer, one cycle after each address.
  - Takes PRE_MIN+1 cycles, then goes to MATCH.
- MATCH:
  - Tries one candidate per PRE_MIN-1 cycles, starting with idx 0 and s = k[0].
  - Each cycle compares step(s) against k[j] and advances j and s.
  - On a mismatch, moves to the next idx and resets j and s.
  - If all PRE_MIN-1 compares pass: found=1, ptrn_idx=idx, s=k[0], go to DEC.
  - If idx 8 fails: found=0, go to DONE with no writes.
- DEC:
  - Two-cycle loop per byte i = 0..MSG_LEN-1.
  - Read cycle: drives mem_addr = CT_BASE+i.
  - Write cycle: mem_wr_en=1, mem_addr = PT_BASE+i, mem_wr_data = {1'b0, ct[i][6:0] ^ s}; then s = step(s).
  - After i = MSG_LEN-1, go to DONE.
- Latency with a pattern found at idx p: (PRE_MIN+1) + p*(PRE_MIN-1) + (PRE_MIN-1) + 2*MSG_LEN cycles from start to ack.
  - Early mismatch exit is permitted to shorten the p term.
  - The bench checks only an upper bound using p = 8.
- DONE: ack=1, and outputs hold. When req=1: ack=0, armed=1, return to IDLE.
- Address arithmetic wraps modulo 2^AW.
- mem_wr_en is never high outside DEC write cycles.
- Parity rule: a byte is bad when ct[i][7] != ^ct[i][6:0]. Bad bytes increment par_err_cnt (saturating) during DEC, whatever the macro setting.

Optional Feature:
PARITY_MARK_EN
- Defined: a bad-parity byte is written as 8'h80 instead of its decrypted value. The LFSR still advances.
- Undefined: bad-parity bytes decrypt normally, and only par_err_cnt records them.

Test Plan:
- "Knowledge comes, but wisdom lingers", pre_length 10, tap 0x60, init 0x01:
  - Expected: found=1, ptrn_idx=0, memory 0..63 equals the space-padded message, par_err_cnt=0.
  - Expected: ack within 11+8*9+9+128 cycles of req falling.
- Same message with tap 0x7B (index 8) and init 0x5A:
  - Expected: ptrn_idx=8, all 64 bytes correct.
  - Expected: no mem_wr_en pulse before DEC.
- Ciphertext all 8'h00 (k constant 0x20, no pattern can produce it):
  - Expected: found=0, ack=1, zero writes, memory 0..63 unchanged.
- Valid ciphertext with bit 7 of byte 30 flipped:
  - Expected: par_err_cnt=1.
  - Expected: byte 30 = 8'h80 with PARITY_MARK_EN, else the correct plaintext; all other bytes correct.
- Reset pulse during DEC after 20 writes:
  - Expected: all outputs at reset values asynchronously, no further writes.
  - Expected: re-arm (req=1 then 0) completes a full correct run.
- Hold req=0 after DONE:
  - Expected: ack stays 1 and no restart occurs.
  - Expected: req=1 drops ack next cycle, and req=0 starts a second identical run.
